// File: rtl/neuron_fxp_pkg.sv
// Shared fixed-point definitions for the neuron datapath: Q4.4 word type,
// its saturation limits and the MAC stage state encoding.
package neuron_fxp_pkg;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;

  typedef logic signed [7:0] q44_t;

  localparam q44_t Q44_MAX = 8'sh7F;
  localparam q44_t Q44_MIN = 8'sh80;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } mac_state_t;

endpackage

// File: rtl/neuron_rescale_sat.sv
// Rescales a Q8.8-scaled accumulator sum down to Q4.4 and saturates it to
// the signed 8-bit range. Purely combinational so other neuron stages can
// reuse it.
// Build option: NEURON_MAC_ROUND_EN selects round-half-up instead of floor.
module neuron_rescale_sat
  import neuron_fxp_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic [ACC_W-1:0] acc_next,
  output q44_t             z_value,
  output logic             z_sat
);

  // One extra bit above the accumulator keeps the rounding add from wrapping.
  localparam int RW = ACC_W + 1 - FRAC_W;
  localparam logic signed [RW-1:0] R_MAX = {{(RW-DATA_W){1'b0}}, Q44_MAX};
  localparam logic signed [RW-1:0] R_MIN = {{(RW-DATA_W){1'b1}}, Q44_MIN};

`ifdef NEURON_MAC_ROUND_EN
  // Half an output LSB, so the floor shift below rounds half up.
  localparam logic [ACC_W:0] ROUND_ADD = {{(ACC_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`else
  localparam logic [ACC_W:0] ROUND_ADD = {(ACC_W+1){1'b0}};
`endif

  logic signed [ACC_W:0]  biased_s;
  logic signed [RW-1:0]   r_s;

  // Drop the fractional bits with an arithmetic shift, then clip to Q4.4.
  always_comb begin
    biased_s = {acc_next[ACC_W-1], acc_next} + ROUND_ADD;
    r_s      = RW'(biased_s >>> FRAC_W);
    if (r_s > R_MAX) begin
      z_value = Q44_MAX;
      z_sat   = 1'b1;
    end else if (r_s < R_MIN) begin
      z_value = Q44_MIN;
      z_sat   = 1'b1;
    end else begin
      z_value = r_s[DATA_W-1:0];
      z_sat   = 1'b0;
    end
  end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Sequential multiply-accumulate stage of one neuron: takes N_INPUTS (x, w)
// beats, adds the bias sampled on the first beat, rescales to Q4.4 with
// saturation and presents the result to the sigmoid stage over valid/ready.
// Build option: NEURON_MAC_ROUND_EN (handled inside neuron_rescale_sat)
// selects round-half-up instead of floor when dropping fractional bits.
module neuron_mac_accumulator
  import neuron_fxp_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 2*DATA_W + $clog2(N_INPUTS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] bias,
  output logic              z_valid,
  input  logic              z_ready,
  output logic [DATA_W-1:0] z_value,
  output logic              z_sat
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  mac_state_t              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [DATA_W-1:0]       z_value_q;
  logic                    z_sat_q;

  logic signed [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]        prod_ext_s;
  logic [ACC_W-1:0]        bias_ext_s;
  logic [ACC_W-1:0]        base_s;
  q44_t                    z_value_d;
  logic                    z_sat_d;
  logic                    last_s;

  // Next accumulator value: bias (aligned to Q8.8) seeds the first beat.
  always_comb begin
    prod_s     = $signed(x_data) * $signed(w_data);
    prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
    bias_ext_s = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
    if (cnt_q == {CNT_W{1'b0}}) begin
      base_s = bias_ext_s;
    end else begin
      base_s = acc_q;
    end
    acc_d  = base_s + prod_ext_s;
    last_s = (cnt_q == CNT_LAST);
  end

  neuron_rescale_sat #(
    .ACC_W (ACC_W)
  ) u_rescale (
    .acc_next (acc_d),
    .z_value  (z_value_d),
    .z_sat    (z_sat_d)
  );

  // Control FSM with beat counter, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ACC;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      z_value_q <= {DATA_W{1'b0}};
      z_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            if (last_s) begin
              cnt_q     <= {CNT_W{1'b0}};
              z_value_q <= z_value_d;
              z_sat_q   <= z_sat_d;
              state_q   <= OUT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            state_q <= ACC;
          end
        end
        OUT: begin
          // Result is held until the sigmoid stage takes it.
          if (z_ready) begin
            state_q <= ACC;
          end else begin
            state_q <= OUT;
          end
        end
        default: begin
          state_q <= ACC;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready = (state_q == ACC);
  assign z_valid  = (state_q == OUT);
  assign z_value  = z_value_q;
  assign z_sat    = z_sat_q;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Self-checking bench for neuron_mac_accumulator: directed vector table,
// backpressure and reset sequences, and randomized neurons against an
// arithmetic reference model.
module tb_neuron_mac_accumulator;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_data;
  logic [7:0] w_data;
  logic [7:0] bias;
  logic       z_valid;
  logic       z_ready;
  logic [7:0] z_value;
  logic       z_sat;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  neuron_mac_accumulator #(.N_INPUTS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_data   (x_data),
    .w_data   (w_data),
    .bias     (bias),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z_value  (z_value),
    .z_sat    (z_sat)
  );

  typedef struct {
    string               name;
    logic [7:0]          b;
    logic [N-1:0][7:0]   x;
    logic [N-1:0][7:0]   w;
    logic [7:0]          ez;
    logic                es;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference: exact integer sum, scale by 1/16 with floor (or round half up), clip.
  function automatic void model(input logic [7:0] b, input logic [N-1:0][7:0] x,
                                input logic [N-1:0][7:0] w, output logic [7:0] z,
                                output logic s);
    int sum;
    int r;
    sum = int'($signed(b)) * 16;
    for (int i = 0; i < N; i++) sum += int'($signed(x[i])) * int'($signed(w[i]));
`ifdef NEURON_MAC_ROUND_EN
    sum += 8;
`endif
    r = sum >>> 4;
    if (r > 127) begin
      z = 8'h7F; s = 1'b1;
    end else if (r < -128) begin
      z = 8'h80; s = 1'b1;
    end else begin
      z = r[7:0]; s = 1'b0;
    end
  endfunction

  function automatic vec_t mk(input string n, input logic [7:0] b, input logic [N-1:0][7:0] x,
                              input logic [N-1:0][7:0] w, input logic [7:0] ez, input logic es);
    vec_t v;
    v.name = n; v.b = b; v.x = x; v.w = w; v.ez = ez; v.es = es;
    return v;
  endfunction

  task automatic run_neuron(input string name, input logic [7:0] b, input logic [N-1:0][7:0] x,
                            input logic [N-1:0][7:0] w, input logic [7:0] ez, input logic es,
                            input bit gaps, input int hold);
    for (int i = 0; i < N; i++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        int idle;
        idle = $urandom_range(3, 1);
        repeat (idle) begin
          @(negedge clk);
          in_valid = 1'b0;
          x_data = 8'($urandom);
          w_data = 8'($urandom);
        end
      end
      @(negedge clk);
      chk({name, "/in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      x_data   = x[i];
      w_data   = w[i];
      bias     = (i == 0) ? b : 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "/z_valid"}, 32'(z_valid), 32'd1);
    chk({name, "/z_value"}, 32'(z_value), 32'(ez));
    chk({name, "/z_sat"},   32'(z_sat),   32'(es));
    if (hold > 0) begin
      in_valid = 1'b1;
      x_data = 8'($urandom);
      w_data = 8'($urandom);
      bias   = 8'($urandom);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({name, "/hold_z_value"}, 32'(z_value), 32'(ez));
        chk({name, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        chk({name, "/hold_z_valid"}, 32'(z_valid), 32'd1);
      end
      in_valid = 1'b0;
    end
    z_ready = 1'b1;
    @(negedge clk);
    z_ready = 1'b0;
    chk({name, "/drain_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "/drain_z_valid"},  32'(z_valid),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]        b;
    logic [N-1:0][7:0] x;
    logic [N-1:0][7:0] w;
    logic [7:0]        ez;
    logic              es;

    rst = 1'b0; in_valid = 1'b0; z_ready = 1'b0;
    x_data = 8'h00; w_data = 8'h00; bias = 8'h00;

    vecs[0] = mk("T1_ones",   8'h00, {4{8'h10}}, {4{8'h10}}, 8'h40, 1'b0);
    vecs[1] = mk("T2_posmax", 8'h7F, {4{8'h7F}}, {4{8'h7F}}, 8'h7F, 1'b1);
    vecs[2] = mk("T2_negmax", 8'h80, {4{8'h80}}, {4{8'h10}}, 8'h80, 1'b1);
`ifdef NEURON_MAC_ROUND_EN
    vecs[3] = mk("T3_half",   8'h00, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h10, 8'h10, 8'h10, 8'h08}, 8'h01, 1'b0);
    vecs[9] = mk("neg_frac",  8'h00, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h10, 8'h10, 8'h10, 8'h01}, 8'h00, 1'b0);
`else
    vecs[3] = mk("T3_half",   8'h00, {8'h00, 8'h00, 8'h00, 8'h01}, {8'h10, 8'h10, 8'h10, 8'h08}, 8'h00, 1'b0);
    vecs[9] = mk("neg_frac",  8'h00, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h10, 8'h10, 8'h10, 8'h01}, 8'hFF, 1'b0);
`endif
    vecs[4] = mk("T3_biasm1", 8'hF0, {4{8'h00}}, {4{8'h10}}, 8'hF0, 1'b0);
    vecs[5] = mk("edge_127",  8'h7F, {4{8'h00}}, {4{8'h10}}, 8'h7F, 1'b0);
    vecs[6] = mk("edge_m128", 8'h80, {4{8'h00}}, {4{8'h10}}, 8'h80, 1'b0);
    vecs[7] = mk("over_128",  8'h7F, {8'h00, 8'h00, 8'h00, 8'h01}, {4{8'h10}}, 8'h7F, 1'b1);
    vecs[8] = mk("under_m129", 8'h80, {8'h00, 8'h00, 8'h00, 8'hFF}, {4{8'h10}}, 8'h80, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/z_valid",  32'(z_valid),  32'd0);
    chk("reset/z_value",  32'(z_value),  32'd0);
    chk("reset/z_sat",    32'(z_sat),    32'd0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++)
      run_neuron(vecs[i].name, vecs[i].b, vecs[i].x, vecs[i].w, vecs[i].ez, vecs[i].es, 1'b0, 1);

    // T4: backpressure for 5 cycles, junk beats offered meanwhile, then a clean neuron
    run_neuron("T4_bp", 8'h00, {4{8'h10}}, {4{8'h10}}, 8'h40, 1'b0, 1'b0, 5);
    run_neuron("T4_after", vecs[3].b, vecs[3].x, vecs[3].w, vecs[3].ez, vecs[3].es, 1'b0, 0);

    // T5: random neurons with input gaps and random backpressure
    for (int n = 0; n < 100; n++) begin
      b = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        x[i] = 8'($urandom);
        w[i] = (n % 3 == 0) ? 8'($urandom_range(16, 0)) : 8'($urandom);
      end
      model(b, x, w, ez, es);
      run_neuron("T5_rand", b, x, w, ez, es, 1'b1, int'($urandom_range(3, 0)));
    end

    // T6: reset after beat 2 of 4, then a fresh neuron
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x_data = 8'h10; w_data = 8'h10;
      bias = (i == 0) ? 8'h30 : 8'h55;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("T6/z_valid",  32'(z_valid),  32'd0);
    chk("T6/in_ready", 32'(in_ready), 32'd1);
    chk("T6/z_value",  32'(z_value),  32'd0);
    b = 8'h08;
    x = {8'h10, 8'h20, 8'hF0, 8'h18};
    w = {8'h20, 8'h10, 8'h10, 8'h08};
    model(b, x, w, ez, es);
    run_neuron("T6_fresh", b, x, w, ez, es, 1'b0, 0);

    // Reset while a result is pending downstream
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x_data = 8'h7F; w_data = 8'h7F; bias = 8'h7F;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("T6o/z_valid_pre", 32'(z_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("T6o/z_valid", 32'(z_valid), 32'd0);
    chk("T6o/z_value", 32'(z_value), 32'd0);
    chk("T6o/z_sat",   32'(z_sat),   32'd0);
    run_neuron("T6o_fresh", b, x, w, ez, es, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
